// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: load/store size selectors,
// FSM state type, byte-enable patterns and the alignment rule.
package mem_pkg;

   // Load size/sign selector (i_mem_rd_src); any other code is treated as LW
   localparam logic [2:0] RD_LB  = 3'b000;
   localparam logic [2:0] RD_LBU = 3'b001;
   localparam logic [2:0] RD_LH  = 3'b010;
   localparam logic [2:0] RD_LHU = 3'b011;
   localparam logic [2:0] RD_LW  = 3'b100;

   // Store size selector (i_mem_wr_src); any other code is treated as SW
   localparam logic [1:0] WR_SB = 2'b00;
   localparam logic [1:0] WR_SH = 2'b01;
   localparam logic [1:0] WR_SW = 2'b10;

   // Little-endian byte-lane enables
   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Half-words need addr[0]=0, words need addr[1:0]=00; bytes never misalign.
   function automatic logic is_misaligned(input logic       is_store,
                                          input logic [2:0] rd_src,
                                          input logic [1:0] wr_src,
                                          input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      if (is_store) begin
         case (wr_src)
            WR_SB:   mis = 1'b0;
            WR_SH:   mis = offset[0];
            default: mis = |offset;
         endcase
      end else begin
         case (rd_src)
            RD_LB, RD_LBU: mis = 1'b0;
            RD_LH, RD_LHU: mis = offset[0];
            default:       mis = |offset;
         endcase
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/half-word lane out
// of the returned memory word and sign- or zero-extends it to bus width.
module mem_load_align
   import mem_pkg::*;
#(
   parameter int BUS_SIZE = 32
) (
   input  logic [2:0]          i_rd_src,
   input  logic [1:0]          i_offset,
   input  logic [BUS_SIZE-1:0] i_word,
   output logic [BUS_SIZE-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection and extension by load type
   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_byte = i_word[7:0];
      w_half = i_word[15:0];
      o_data = i_word;

      case (i_offset)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase

      w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

      case (i_rd_src)
         RD_LB:   o_data = {{(BUS_SIZE-8){w_byte[7]}}, w_byte};
         RD_LBU:  o_data = {{(BUS_SIZE-8){1'b0}}, w_byte};
         RD_LH:   o_data = {{(BUS_SIZE-16){w_half[15]}}, w_half};
         RD_LHU:  o_data = {{(BUS_SIZE-16){1'b0}}, w_half};
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory-access stage. Non-memory instructions pass through with one
// cycle of latency; loads/stores are captured, issued on a req/ack data-memory
// port and stall upstream until ack, misalignment or bus timeout.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int BUS_SIZE      = 32,
   parameter int MEM_ADDR_SIZE = 5,
   parameter int DM_ADDR_SIZE  = 10,
   parameter int TIMEOUT       = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_enable,
   input  logic [2:0]               i_mem_rd_src,
   input  logic [1:0]               i_mem_wr_src,
   input  logic                     i_mem_write,
   input  logic                     i_mem_to_reg,
   input  logic                     i_wb,
   input  logic                     i_halt,
   input  logic [BUS_SIZE-1:0]      i_bus_b,
   input  logic [BUS_SIZE-1:0]      i_alu_result,
   input  logic [MEM_ADDR_SIZE-1:0] i_addr_wr,
   output logic                     o_dm_req,
   output logic                     o_dm_we,
   output logic [3:0]               o_dm_be,
   output logic [DM_ADDR_SIZE-1:0]  o_dm_addr,
   output logic [BUS_SIZE-1:0]      o_dm_wdata,
   input  logic                     i_dm_ack,
   input  logic [BUS_SIZE-1:0]      i_dm_rdata,
   output logic                     o_stall,
   output logic                     o_wb,
   output logic                     o_mem_to_reg,
   output logic                     o_halt,
   output logic [BUS_SIZE-1:0]      o_mem_data,
   output logic [BUS_SIZE-1:0]      o_alu_result,
   output logic [MEM_ADDR_SIZE-1:0] o_addr_wr,
   output logic                     o_misalign,
   output logic                     o_bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // FSM
   state_t r_state;
   state_t w_state_next;

   // Captured transaction
   logic [BUS_SIZE-1:0]      r_c_addr;
   logic [BUS_SIZE-1:0]      r_c_wdata;
   logic [3:0]               r_c_be;
   logic                     r_c_we;
   logic                     r_c_load;
   logic [2:0]               r_c_rd_src;
   logic                     r_c_wb;
   logic                     r_c_halt;
   logic [MEM_ADDR_SIZE-1:0] r_c_addr_wr;
   logic [CNT_W-1:0]         r_cnt;

   // Registered stage outputs
   logic                     r_wb;
   logic                     r_mem_to_reg;
   logic                     r_halt;
   logic [BUS_SIZE-1:0]      r_mem_data;
   logic [BUS_SIZE-1:0]      r_alu_result;
   logic [MEM_ADDR_SIZE-1:0] r_addr_wr;
   logic                     r_misalign;
   logic                     r_bus_err;

   // Control strobes from the FSM
   logic w_mem_op;
   logic w_misaligned;
   logic w_cnt_last;
   logic w_wait;
   logic w_stall;
   logic w_capture;
   logic w_pass;
   logic w_misalign;
   logic w_done_ok;
   logic w_done_err;

   // Store lane formatting and load formatting
   logic [3:0]          w_st_be;
   logic [BUS_SIZE-1:0] w_st_wdata;
   logic [BUS_SIZE-1:0] w_load_data;

   assign w_mem_op     = i_mem_write | i_mem_to_reg;
   assign w_misaligned = is_misaligned(i_mem_write, i_mem_rd_src, i_mem_wr_src,
                                       i_alu_result[1:0]);
   assign w_cnt_last   = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_wait       = (r_state == ST_WAIT);

   // Store data replication and byte enables from size and low address bits
   always_comb begin
      w_st_be    = BE_WORD;
      w_st_wdata = i_bus_b;
      case (i_mem_wr_src)
         WR_SB: begin
            w_st_be    = BE_BYTE << i_alu_result[1:0];
            w_st_wdata = {(BUS_SIZE/8){i_bus_b[7:0]}};
         end
         WR_SH: begin
            w_st_be    = i_alu_result[1] ? BE_HALF_HI : BE_HALF_LO;
            w_st_wdata = {(BUS_SIZE/16){i_bus_b[15:0]}};
         end
         default: begin
            w_st_be    = BE_WORD;
            w_st_wdata = i_bus_b;
         end
      endcase
   end

   mem_load_align #(
      .BUS_SIZE (BUS_SIZE)
   ) u_load_align (
      .i_rd_src (r_c_rd_src),
      .i_offset (r_c_addr[1:0]),
      .i_word   (i_dm_rdata),
      .o_data   (w_load_data)
   );

   // State register
   // NOTE: asynchronous active-low reset; reset is the only thing outside the clock in the sensitivity list.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: non-blocking assignment for every flop so all registers sample the same pre-edge values.
         r_state <= w_state_next;
      end
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_capture    = 1'b0;
      w_pass       = 1'b0;
      w_misalign   = 1'b0;
      w_done_ok    = 1'b0;
      w_done_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_enable) begin
               if (!w_mem_op) begin
                  w_pass = 1'b1;
               end else if (w_misaligned) begin
                  w_misalign = 1'b1;
               end else begin
                  w_capture    = 1'b1;
                  w_stall      = 1'b1;
                  w_state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // i_enable is deliberately ignored: a debug pause never aborts a bus cycle
            if (i_dm_ack) begin
               w_done_ok    = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_cnt_last) begin
               w_done_err   = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Transaction capture and WAIT-cycle counter
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_c_addr    <= '0;
         r_c_wdata   <= '0;
         r_c_be      <= BE_NONE;
         r_c_we      <= 1'b0;
         r_c_load    <= 1'b0;
         r_c_rd_src  <= '0;
         r_c_wb      <= 1'b0;
         r_c_halt    <= 1'b0;
         r_c_addr_wr <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_capture) begin
            r_c_addr    <= i_alu_result;
            r_c_wdata   <= w_st_wdata;
            r_c_be      <= i_mem_write ? w_st_be : BE_WORD;
            r_c_we      <= i_mem_write;
            r_c_load    <= i_mem_to_reg;
            r_c_rd_src  <= i_mem_rd_src;
            r_c_wb      <= i_wb;
            r_c_halt    <= i_halt;
            r_c_addr_wr <= i_addr_wr;
         end
         if (w_capture || w_done_ok || w_done_err) begin
            r_cnt <= '0;
         end else if (w_wait) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Stage output registers: update on pass-through, misalign or completion, else hold
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wb         <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_halt       <= 1'b0;
         r_mem_data   <= '0;
         r_alu_result <= '0;
         r_addr_wr    <= '0;
         r_misalign   <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_misalign <= w_misalign;
         r_bus_err  <= w_done_err;
         if (w_pass || w_misalign) begin
            r_wb         <= i_wb & ~w_misalign;
            r_mem_to_reg <= i_mem_to_reg;
            r_halt       <= i_halt;
            r_alu_result <= i_alu_result;
            r_addr_wr    <= i_addr_wr;
         end
         if (w_done_ok || w_done_err) begin
            r_wb         <= r_c_wb & w_done_ok;
            r_mem_to_reg <= r_c_load;
            r_halt       <= r_c_halt;
            r_alu_result <= r_c_addr;
            r_addr_wr    <= r_c_addr_wr;
            if (w_done_ok && r_c_load && !r_c_we) begin
               r_mem_data <= w_load_data;
            end
         end
      end
   end

   // Stall is qualified by reset so a held-in-reset stage never freezes upstream
   assign o_stall      = w_stall & i_reset;

   assign o_dm_req     = w_wait;
   assign o_dm_we      = w_wait & r_c_we;
   assign o_dm_be      = w_wait ? r_c_be : BE_NONE;
   assign o_dm_addr    = w_wait ? r_c_addr[DM_ADDR_SIZE+1:2] : '0;
   assign o_dm_wdata   = w_wait ? r_c_wdata : '0;

   assign o_wb         = r_wb;
   assign o_mem_to_reg = r_mem_to_reg;
   assign o_halt       = r_halt;
   assign o_mem_data   = r_mem_data;
   assign o_alu_result = r_alu_result;
   assign o_addr_wr    = r_addr_wr;
   assign o_misalign   = r_misalign;
   assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues directed and random
// operations, emulates the data memory and pushes the expected stage outputs;
// an independent monitor detects commits from the port activity and compares.
module tb_mem_access_unit;

   localparam int TIMEOUT = 16;

   logic        i_clk;
   logic        i_reset;
   logic        i_enable;
   logic [2:0]  i_mem_rd_src;
   logic [1:0]  i_mem_wr_src;
   logic        i_mem_write;
   logic        i_mem_to_reg;
   logic        i_wb;
   logic        i_halt;
   logic [31:0] i_bus_b;
   logic [31:0] i_alu_result;
   logic [4:0]  i_addr_wr;
   logic        o_dm_req;
   logic        o_dm_we;
   logic [3:0]  o_dm_be;
   logic [9:0]  o_dm_addr;
   logic [31:0] o_dm_wdata;
   logic        i_dm_ack;
   logic [31:0] i_dm_rdata;
   logic        o_stall;
   logic        o_wb;
   logic        o_mem_to_reg;
   logic        o_halt;
   logic [31:0] o_mem_data;
   logic [31:0] o_alu_result;
   logic [4:0]  o_addr_wr;
   logic        o_misalign;
   logic        o_bus_err;

   mem_access_unit #(
      .BUS_SIZE      (32),
      .MEM_ADDR_SIZE (5),
      .DM_ADDR_SIZE  (10),
      .TIMEOUT       (TIMEOUT)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_mem_rd_src (i_mem_rd_src),
      .i_mem_wr_src (i_mem_wr_src),
      .i_mem_write  (i_mem_write),
      .i_mem_to_reg (i_mem_to_reg),
      .i_wb         (i_wb),
      .i_halt       (i_halt),
      .i_bus_b      (i_bus_b),
      .i_alu_result (i_alu_result),
      .i_addr_wr    (i_addr_wr),
      .o_dm_req     (o_dm_req),
      .o_dm_we      (o_dm_we),
      .o_dm_be      (o_dm_be),
      .o_dm_addr    (o_dm_addr),
      .o_dm_wdata   (o_dm_wdata),
      .i_dm_ack     (i_dm_ack),
      .i_dm_rdata   (i_dm_rdata),
      .o_stall      (o_stall),
      .o_wb         (o_wb),
      .o_mem_to_reg (o_mem_to_reg),
      .o_halt       (o_halt),
      .o_mem_data   (o_mem_data),
      .o_alu_result (o_alu_result),
      .o_addr_wr    (o_addr_wr),
      .o_misalign   (o_misalign),
      .o_bus_err    (o_bus_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic        wb;
      logic        m2r;
      logic        halt;
      logic        misalign;
      logic        bus_err;
      logic [31:0] alu;
      logic [31:0] mdata;
      logic [4:0]  awr;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   bit          fire_prev;
   int          n_checks;
   int          n_errors;
   logic [31:0] mem_model [1024];
   logic [31:0] last_mdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Access size in bytes
   function automatic int op_size(input bit store, input logic [2:0] rd, input logic [1:0] wr);
      if (store) return (wr == 2'd0) ? 1 : (wr == 2'd1) ? 2 : 4;
      return (rd <= 3'd1) ? 1 : (rd <= 3'd3) ? 2 : 4;
   endfunction

   // Loaded value by shifting the word right to the addressed byte, masking and extending
   function automatic logic [31:0] load_value(input logic [31:0] word, input logic [2:0] rd,
                                              input logic [1:0] off);
      logic [31:0] sh;
      logic [31:0] v;
      sh = word >> (8 * off);
      case (rd)
         3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
         3'd1: v = sh & 32'hFF;
         3'd2: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
         3'd3: v = sh & 32'hFFFF;
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] wr, input logic [1:0] off);
      logic [3:0] one;
      logic [3:0] two;
      one = 4'b0001;
      two = 4'b0011;
      if (wr == 2'd0) return one << off;
      if (wr == 2'd1) return two << off;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] wr, input logic [31:0] d);
      if (wr == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (wr == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   task automatic set_junk();
      i_mem_rd_src = 3'($urandom);
      i_mem_wr_src = 2'($urandom);
      i_mem_write  = 1'($urandom);
      i_mem_to_reg = 1'($urandom);
      i_wb         = 1'($urandom);
      i_halt       = 1'($urandom);
      i_bus_b      = $urandom;
      i_alu_result = $urandom;
      i_addr_wr    = 5'($urandom);
   endtask

   // Idle cycles with enable low: random ops and stray acks must be ignored
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         set_junk();
         i_enable   = 1'b0;
         i_dm_ack   = 1'($urandom);
         i_dm_rdata = $urandom;
         #1;
         check("idle_no_req", 32'(o_dm_req), 32'd0);
         check("idle_no_stall", 32'(o_stall), 32'd0);
         @(posedge i_clk); #1;
      end
      i_dm_ack = 1'b0;
   endtask

   // Issue one operation; starts and ends just after a rising edge.
   // lat = number of ack-less WAIT cycles before ack; negative = never ack.
   task automatic do_op(input bit wr, input bit ld, input logic [2:0] rd, input logic [1:0] wsrc,
                        input logic [31:0] addr, input logic [31:0] bus_b, input bit wb,
                        input bit halt, input logic [4:0] awr, input int lat);
      exp_t e;
      bit   memop;
      bit   mis;
      int   idx;
      bit   ack;
      logic [3:0]  be;
      logic [31:0] wd;
      memop = wr | ld;
      mis   = memop && ((int'(addr[1:0]) % op_size(wr, rd, wsrc)) != 0);
      idx   = int'(addr[11:2]);
      be    = store_be(wsrc, addr[1:0]);
      wd    = store_wdata(wsrc, bus_b);

      i_enable = 1'b1;  i_mem_write = wr;   i_mem_to_reg = ld;
      i_mem_rd_src = rd; i_mem_wr_src = wsrc; i_alu_result = addr;
      i_bus_b = bus_b;  i_wb = wb;  i_halt = halt;  i_addr_wr = awr;
      i_dm_ack = 1'($urandom);  i_dm_rdata = $urandom;

      e.alu = addr;  e.awr = awr;  e.halt = halt;  e.mdata = last_mdata;
      e.misalign = 1'b0;  e.bus_err = 1'b0;  e.m2r = ld;  e.wb = wb;
      if (!memop) begin
         e.m2r = 1'b0;
      end else if (mis) begin
         e.wb = 1'b0;  e.misalign = 1'b1;
      end else if (lat < 0) begin
         e.wb = 1'b0;  e.bus_err = 1'b1;
      end else if (ld && !wr) begin
         e.mdata    = load_value(mem_model[idx], rd, addr[1:0]);
         last_mdata = e.mdata;
      end
      sb.push_back(e);

      #1;
      check("stall_issue", 32'(o_stall), 32'(memop && !mis));
      @(posedge i_clk); #1;

      if (memop && !mis) begin
         for (int k = 0; k < TIMEOUT; k++) begin
            ack = (k == lat);
            set_junk();
            i_enable   = 1'($urandom);
            i_dm_ack   = ack;
            i_dm_rdata = ack ? mem_model[idx] : $urandom;
            #1;
            check("dm_req", 32'(o_dm_req), 32'd1);
            check("dm_addr", 32'(o_dm_addr), 32'(idx));
            check("dm_we", 32'(o_dm_we), 32'(wr));
            if (wr) begin
               check("dm_be", 32'(o_dm_be), 32'(be));
               check("dm_wdata", o_dm_wdata, wd);
            end
            check("stall_wait", 32'(o_stall), 32'(!ack && (k != TIMEOUT - 1)));
            if (ack && wr) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) mem_model[idx][8*b +: 8] = wd[8*b +: 8];
            end
            @(posedge i_clk); #1;
            if (ack) break;
         end
         i_dm_ack = 1'b0;
      end
   endtask

   // Reset asserted mid-cycle during the third WAIT cycle of a load
   task automatic reset_mid_wait();
      i_enable = 1'b1;  i_mem_write = 1'b0;  i_mem_to_reg = 1'b1;
      i_mem_rd_src = 3'd4;  i_alu_result = 32'h0000_0300;  i_wb = 1'b1;
      i_dm_ack = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      check("rst_pre_req", 32'(o_dm_req), 32'd1);
      #1 i_reset = 1'b0;
      last_mdata = '0;
      #1;
      check("rst_req", 32'(o_dm_req), 32'd0);
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_be", 32'(o_dm_be), 32'd0);
      check("rst_alu", o_alu_result, 32'd0);
      check("rst_mdata", o_mem_data, 32'd0);
      @(posedge i_clk); #1;
      check("rst_hold_stall", 32'(o_stall), 32'd0);
      i_enable = 1'b0;
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      @(posedge i_clk); #1;
   endtask

   // Monitor: a commit happens at the edge after a cycle where the stage was
   // not stalled and either completed a request or had enable high in idle.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         sb.delete();
         cur       = '0;
         fire_prev = 1'b0;
         check("reset_req", 32'(o_dm_req), 32'd0);
         check("reset_stall", 32'(o_stall), 32'd0);
         check("reset_wb", 32'(o_wb), 32'd0);
      end else begin
         if (fire_prev) begin
            if (sb.size() == 0) check("unexpected_commit", 32'd0, 32'd1);
            else cur = sb.pop_front();
         end else begin
            cur.misalign = 1'b0;
            cur.bus_err  = 1'b0;
         end
         check("o_wb", 32'(o_wb), 32'(cur.wb));
         check("o_mem_to_reg", 32'(o_mem_to_reg), 32'(cur.m2r));
         check("o_halt", 32'(o_halt), 32'(cur.halt));
         check("o_alu_result", o_alu_result, cur.alu);
         check("o_addr_wr", 32'(o_addr_wr), 32'(cur.awr));
         check("o_mem_data", o_mem_data, cur.mdata);
         check("o_misalign", 32'(o_misalign), 32'(cur.misalign));
         check("o_bus_err", 32'(o_bus_err), 32'(cur.bus_err));
         fire_prev = o_dm_req ? !o_stall : (i_enable && !o_stall);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      int r;
      int lat;
      logic [31:0] addr;
      n_checks = 0;  n_errors = 0;
      fire_prev = 1'b0;  cur = '0;  last_mdata = '0;
      for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
      i_reset = 1'b0;  i_enable = 1'b0;  i_dm_ack = 1'b0;  i_dm_rdata = '0;
      set_junk();

      repeat (3) @(posedge i_clk);
      #1;
      i_enable = 1'b1;  i_mem_write = 1'b1;  i_mem_wr_src = 2'd2;  i_alu_result = '0;
      #1;
      check("reset_stall_gated", 32'(o_stall), 32'd0);
      check("reset_be", 32'(o_dm_be), 32'd0);
      i_enable = 1'b0;
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      @(posedge i_clk); #1;

      // Directed cases
      do_op(0, 0, 3'd0, 2'd0, 32'h0000_0007, 32'h0, 1, 0, 5'd3, 0);
      mem_model[32'h103 >> 2] = 32'h80FF_FFFF;
      do_op(0, 1, 3'd0, 2'd0, 32'h0000_0103, 32'h0, 1, 0, 5'd5, 0);
      check("lb_directed", o_mem_data, 32'hFFFF_FF80);
      do_op(1, 0, 3'd0, 2'd1, 32'h0000_0022, 32'h0000_BEEF, 0, 0, 5'd0, 1);
      do_op(0, 1, 3'd4, 2'd0, 32'h0000_0101, 32'h0, 1, 0, 5'd9, 0);
      do_op(0, 1, 3'd4, 2'd0, 32'h0000_0200, 32'h0, 1, 0, 5'd7, -1);
      idle_cycles(2);
      reset_mid_wait();
      idle_cycles(1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         r    = $urandom_range(0, 19);
         lat  = (r == 0) ? -1 : (r % 4);
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         if (kind <= 3)
            do_op(0, 0, 3'($urandom), 2'($urandom), addr, $urandom, 1'($urandom),
                  1'($urandom_range(0, 15) == 0), 5'($urandom), lat);
         else if (kind <= 6)
            do_op(0, 1, 3'($urandom), 2'($urandom), addr, $urandom, 1'($urandom),
                  1'b0, 5'($urandom), lat);
         else
            do_op(1, 0, 3'($urandom), 2'($urandom), addr, $urandom, 1'($urandom),
                  1'b0, 5'($urandom), lat);
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(3);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have these parameters: BUS_SIZE 32, data bus width; MEM_ADDR_SIZE 5, register-file address width; DM_ADDR_SIZE 10, data-memory word-address width; TIMEOUT 16, maximum WAIT cycles before a bus error.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_reset  in  1  asynchronous active-low reset.
REQ-005 i_enable  in  1  debug step enable; gates new-operation acceptance only.
REQ-006 i_mem_rd_src in 3 (000 LB, 001 LBU, 010 LH, 011 LHU, others LW); i_mem_wr_src in 2 (00 SB, 01 SH, others SW); i_mem_write in 1; i_mem_to_reg in 1 (load); i_wb in 1; i_halt in 1.
REQ-007 i_bus_b in BUS_SIZE (store data); i_alu_result in BUS_SIZE (byte address or ALU result); i_addr_wr in MEM_ADDR_SIZE (destination register).
REQ-008 o_dm_req out 1; o_dm_we out 1; o_dm_be out 4; o_dm_addr out DM_ADDR_SIZE; o_dm_wdata out BUS_SIZE; i_dm_ack in 1; i_dm_rdata in BUS_SIZE.
REQ-009 o_stall out 1 (holds upstream stages); o_wb, o_mem_to_reg, o_halt out 1; o_mem_data, o_alu_result out BUS_SIZE; o_addr_wr out MEM_ADDR_SIZE; o_misalign, o_bus_err out 1 (one-cycle pulses).

Function
REQ-010 The FSM SHALL have two states: IDLE and WAIT.
REQ-011 In IDLE with i_enable=1 and neither i_mem_write nor i_mem_to_reg, the block SHALL register i_wb, i_mem_to_reg, i_halt, i_alu_result and i_addr_wr into the outputs on the next edge, with 1-cycle latency and o_stall=0.
REQ-012 In IDLE with i_enable=1 and a memory op, the block SHALL assert o_stall combinationally, capture the address, data and control, and enter WAIT; the outputs SHALL hold.
REQ-013 In WAIT, o_dm_req SHALL be 1 and o_dm_addr SHALL equal the captured address[DM_ADDR_SIZE+1:2]; o_dm_we SHALL equal the captured mem_write.
REQ-014 In WAIT, o_stall SHALL be 1 while i_dm_ack=0; on i_dm_ack=1, o_stall SHALL be 0 in that cycle and the block SHALL update the outputs and return to IDLE; minimum memory-op latency is 2 cycles.
REQ-015 Stores SHALL use little-endian lanes: SB replicates the byte into all lanes with be=0001<<addr[1:0]; SH replicates the half with be=0011 or 1100 by addr[1]; SW uses be=1111.
REQ-016 Loads SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through to o_mem_data.
REQ-017 A misaligned access (half-word with addr[0]=1, word with addr[1:0]!=00) SHALL not issue a request: stay in IDLE, pulse o_misalign, and register outputs with o_wb=0; o_stall=0.
REQ-018 A WAIT cycle counter SHALL reach TIMEOUT without ack -> pulse o_bus_err, force o_wb=0, return to IDLE, o_stall=0 that cycle.
REQ-019 i_enable=0 in IDLE SHALL hold all outputs and issue nothing; i_enable=0 in WAIT SHALL NOT abort the transaction.
REQ-020 An ack arriving in IDLE SHALL be ignored.

Reset
REQ-021 Asserting i_reset SHALL immediately force IDLE, a zero counter, and all outputs to 0 (including o_dm_req, o_stall, o_dm_be), including mid-WAIT; the pending transaction is discarded.
REQ-022 Reset release SHALL take effect on the next rising edge only.

Structure
REQ-023 Shared package mem_pkg SHALL hold the rd_src/wr_src encodings, the FSM state type, and the byte-enable constants.
REQ-024 Load lane extraction and extension SHALL be a combinational sub-module, mem_load_align.

Verification
REQ-025 ALU op, alu_result=0x00000007, wb=1 -> o_alu_result=0x00000007 after 1 cycle, o_stall never 1.
REQ-026 LB addr 0x103, rdata 0x80FFFFFF, ack on the 1st WAIT cycle -> o_mem_data=0xFFFFFF80, o_stall high 1 cycle.
REQ-027 SH addr 0x22, bus_b=0x0000BEEF -> o_dm_be=1100, o_dm_wdata=0xBEEFBEEF, o_dm_addr=0x008.
REQ-028 LW addr 0x101 -> o_misalign pulse, no o_dm_req, o_wb=0.
REQ-029 LW with ack never asserted -> o_bus_err after 16 WAIT cycles, stall released.
REQ-030 Reset asserted in the 3rd WAIT cycle -> o_dm_req=0 and o_stall=0 immediately, outputs 0.
